// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding, oversampling constants and the
// 2-of-3 majority helper used by both receiver and transmitter.
package uart_pkg;

  localparam int unsigned OVERSAMPLE = 16;
  localparam int unsigned SAMPLE_MID = 8;
  localparam int unsigned CNT_W      = $clog2(OVERSAMPLE);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } uart_state_e;

  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage : uart_pkg

// File: rtl/uart_rx_sync.sv
// Two-flop synchronizer for the serial line plus the mid-bit 2-of-3 voter.
// vote_c is valid on the tick where cnt_i sits one past SAMPLE_MID.
module uart_rx_sync
  import uart_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             tick_i,
  input  logic             rx_i,
  input  logic [CNT_W-1:0] cnt_i,
  output logic             rx_sync_o,
  output logic             vote_c
);

  logic [1:0] sync_q;
  logic [1:0] smp_q;

  // Flops reset to the idle level so release never looks like a start bit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= 2'b11;
      smp_q  <= 2'b11;
    end else begin
      sync_q <= {sync_q[0], rx_i};
      if (tick_i && (cnt_i == CNT_W'(SAMPLE_MID - 1))) smp_q[0] <= sync_q[1];
      if (tick_i && (cnt_i == CNT_W'(SAMPLE_MID)))     smp_q[1] <= sync_q[1];
    end
  end

  assign rx_sync_o = sync_q[1];
  assign vote_c    = maj3(smp_q[0], smp_q[1], sync_q[1]);

endmodule : uart_rx_sync

// File: rtl/uart_rx.sv
// 16x oversampling UART receiver with valid/ready output and error pulses.
// Optional parity bit compiled in with UART_RX_PARITY_EN.
module uart_rx
  import uart_pkg::*;
#(
  parameter int unsigned DATA_BITS  = 8,
  parameter bit          PARITY_ODD = 1'b0
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 rx_tick,
  input  logic                 rx,
  input  logic                 rx_ready,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  output logic                 frame_err,
  output logic                 parity_err,
  output logic                 overrun,
  output logic                 busy
);

  localparam int unsigned BIDX_W = $clog2(DATA_BITS);

  uart_state_e          state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [BIDX_W-1:0]    bidx_q, bidx_d;
  logic [DATA_BITS-1:0] word_q, word_d;
  logic [DATA_BITS-1:0] data_q, data_d;
  logic                 par_q, par_d;
  logic                 perr_q, perr_d;
  logic                 done_q, done_d;
  logic                 valid_q, valid_d;
  logic                 fe_q, fe_d;
  logic                 pe_q, pe_d;
  logic                 ovr_q, ovr_d;
  logic                 busy_q, busy_d;
  logic                 rx_sync, vote_c, vote_tick, last_tick;

  uart_rx_sync u_sync (
    .clk       (clk),
    .rst_n     (rst_n),
    .tick_i    (rx_tick),
    .rx_i      (rx),
    .cnt_i     (cnt_q),
    .rx_sync_o (rx_sync),
    .vote_c    (vote_c)
  );

  assign vote_tick = (cnt_q == CNT_W'(SAMPLE_MID + 1));
  assign last_tick = (cnt_q == CNT_W'(OVERSAMPLE - 1));

  // Frame sequencing; par_q accumulates the expected parity bit as data arrives.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bidx_d  = bidx_q;
    word_d  = word_q;
    par_d   = par_q;
    perr_d  = perr_q;
    done_d  = 1'b0;
    fe_d    = 1'b0;
    pe_d    = 1'b0;
    if (rx_tick) begin
      cnt_d = cnt_q + CNT_W'(1);
      case (state_q)
        ST_IDLE: begin
          cnt_d = '0;
          if (!rx_sync) begin
            state_d = ST_START;
            bidx_d  = '0;
            par_d   = PARITY_ODD;
            perr_d  = 1'b0;
          end
        end
        ST_START: begin
          if (vote_tick && vote_c) begin
            state_d = ST_IDLE;
            cnt_d   = '0;
          end else if (last_tick) begin
            state_d = ST_DATA;
          end
        end
        ST_DATA: begin
          if (vote_tick) begin
            word_d[bidx_q] = vote_c;
            par_d          = par_q ^ vote_c;
          end
          if (last_tick) begin
            if (bidx_q == BIDX_W'(DATA_BITS - 1)) begin
`ifdef UART_RX_PARITY_EN
              state_d = ST_PARITY;
`else
              state_d = ST_STOP;
`endif
            end else begin
              bidx_d = bidx_q + BIDX_W'(1);
            end
          end
        end
`ifdef UART_RX_PARITY_EN
        ST_PARITY: begin
          if (vote_tick && (vote_c != par_q)) begin
            pe_d   = 1'b1;
            perr_d = 1'b1;
          end
          if (last_tick) state_d = ST_STOP;
        end
`endif
        ST_STOP: begin
          if (vote_tick) begin
            state_d = ST_IDLE;
            cnt_d   = '0;
            if (!vote_c) fe_d = 1'b1;
            else         done_d = !perr_q;
          end
        end
        default: begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end
      endcase
    end
  end

  // Output handshake: a completed word loads unless the holding register is stuck.
  always_comb begin
    data_d  = data_q;
    valid_d = valid_q;
    ovr_d   = 1'b0;
    busy_d  = (state_d != ST_IDLE);
    if (valid_q && rx_ready) valid_d = 1'b0;
    if (done_q) begin
      if (!valid_q || rx_ready) begin
        data_d  = word_q;
        valid_d = 1'b1;
      end else begin
        ovr_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      bidx_q  <= '0;
      word_q  <= '0;
      data_q  <= '0;
      par_q   <= 1'b0;
      perr_q  <= 1'b0;
      done_q  <= 1'b0;
      valid_q <= 1'b0;
      fe_q    <= 1'b0;
      pe_q    <= 1'b0;
      ovr_q   <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bidx_q  <= bidx_d;
      word_q  <= word_d;
      data_q  <= data_d;
      par_q   <= par_d;
      perr_q  <= perr_d;
      done_q  <= done_d;
      valid_q <= valid_d;
      fe_q    <= fe_d;
      pe_q    <= pe_d;
      ovr_q   <= ovr_d;
      busy_q  <= busy_d;
    end
  end

  assign rx_data    = data_q;
  assign rx_valid   = valid_q;
  assign frame_err  = fe_q;
  assign parity_err = pe_q;
  assign overrun    = ovr_q;
  assign busy       = busy_q;

endmodule : uart_rx

// File: tb/tb_uart_rx.sv
// Scoreboard bench for uart_rx: serial frames are generated from the bit-level
// frame format, expected words/flags are queued and a monitor checks deliveries.
module tb_uart_rx;

  localparam int unsigned DB      = 8;
  localparam bit          PODD    = 1'b0;
  localparam int unsigned BIT_CLK = 16;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          rx_tick;
  logic          rx;
  logic          rx_ready;
  logic [DB-1:0] rx_data;
  logic          rx_valid;
  logic          frame_err;
  logic          parity_err;
  logic          overrun;
  logic          busy;

  always #5 clk = ~clk;

  uart_rx #(.DATA_BITS(DB), .PARITY_ODD(PODD)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .rx_tick    (rx_tick),
    .rx         (rx),
    .rx_ready   (rx_ready),
    .rx_data    (rx_data),
    .rx_valid   (rx_valid),
    .frame_err  (frame_err),
    .parity_err (parity_err),
    .overrun    (overrun),
    .busy       (busy)
  );

  int checks = 0;
  int errors = 0;
  logic [DB-1:0] exp_q[$];
  logic [DB-1:0] exp_word;
  int exp_fe = 0, exp_pe = 0, exp_ovr = 0;
  int seen_fe = 0, seen_pe = 0, seen_ovr = 0;

  task automatic check(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, req, $time);
    end
  endtask

  // Monitor: every accepted word must match the head of the expected queue.
  always @(negedge clk) begin
    if (rst_n) begin
      if (rx_valid && rx_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_word: got 0x%0h, expected no word at %0t", rx_data, $time);
        end else begin
          exp_word = exp_q.pop_front();
          check("rx_data", int'(rx_data), int'(exp_word));
        end
      end
      if (frame_err)  seen_fe++;
      if (parity_err) seen_pe++;
      if (overrun)    seen_ovr++;
    end
  end

  task automatic clks(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_bit(input logic b);
    rx = b;
    clks(BIT_CLK);
  endtask

  // Build one frame on the line and record what the receiver should report.
  task automatic send_frame(input logic [DB-1:0] d, input logic stop_b, input logic par_flip);
    logic good;
    good = stop_b;
`ifdef UART_RX_PARITY_EN
    if (par_flip) begin
      good = 1'b0;
      exp_pe++;
    end
`endif
    if (!stop_b) exp_fe++;
    if (good) begin
      if (exp_q.size() > 0 && !rx_ready) exp_ovr++;
      else exp_q.push_back(d);
    end
    send_bit(1'b0);
    for (int i = 0; i < int'(DB); i++) send_bit(d[i]);
`ifdef UART_RX_PARITY_EN
    send_bit((^d) ^ PODD ^ par_flip);
`else
    if (par_flip) good = good;
`endif
    send_bit(stop_b);
    rx = 1'b1;
    clks(4);
  endtask

  task automatic check_counts(input string tag);
    check({tag, "_frame_err"},  seen_fe,  exp_fe);
    check({tag, "_parity_err"}, seen_pe,  exp_pe);
    check({tag, "_overrun"},    seen_ovr, exp_ovr);
  endtask

  initial begin
    rx_tick  = 1'b1;
    rx       = 1'b1;
    rx_ready = 1'b1;
    rst_n    = 1'b0;
    clks(3);
    check("reset_rx_valid",   int'(rx_valid),   0);
    check("reset_rx_data",    int'(rx_data),    0);
    check("reset_busy",       int'(busy),       0);
    check("reset_frame_err",  int'(frame_err),  0);
    check("reset_parity_err", int'(parity_err), 0);
    check("reset_overrun",    int'(overrun),    0);
    rst_n = 1'b1;
    clks(5);

    // Clean frame with consumer ready.
    send_frame(8'hA5, 1'b1, 1'b0);
    check("a5_busy_after", int'(busy), 0);
    check("a5_queue_empty", exp_q.size(), 0);
    check_counts("a5");

    // Short low glitch: false start, no word, no flags.
    rx = 1'b0;
    clks(5);
    rx = 1'b1;
    check("glitch_busy_high", int'(busy), 1);
    clks(40);
    check("glitch_busy_low", int'(busy), 0);
    check("glitch_no_valid", int'(rx_valid), 0);
    check_counts("glitch");

    // Stop bit low: framing error, word discarded.
    send_frame(8'h3C, 1'b0, 1'b0);
    check("ferr_no_valid", int'(rx_valid), 0);
    check_counts("ferr");

    // Stalled consumer: second word overruns, first held.
    rx_ready = 1'b0;
    send_frame(8'h11, 1'b1, 1'b0);
    send_frame(8'h22, 1'b1, 1'b0);
    check("ovr_valid_held", int'(rx_valid), 1);
    check("ovr_data_held", int'(rx_data), 'h11);
    check_counts("ovr");
    rx_ready = 1'b1;
    clks(1);
    check("ovr_valid_cleared", int'(rx_valid), 0);
    check("ovr_queue_empty", exp_q.size(), 0);

    // Reset in the middle of bit 4 of 0xFF, then a clean frame.
    send_bit(1'b0);
    for (int i = 0; i < 4; i++) send_bit(1'b1);
    clks(8);
    rst_n = 1'b0;
    clks(2);
    check("midreset_busy", int'(busy), 0);
    check("midreset_valid", int'(rx_valid), 0);
    rst_n = 1'b1;
    clks(40);
    check("midreset_idle", int'(busy), 0);
    send_frame(8'h5A, 1'b1, 1'b0);
    check("midreset_queue_empty", exp_q.size(), 0);
    check_counts("midreset");

`ifdef UART_RX_PARITY_EN
    send_frame(8'h07, 1'b1, 1'b1);
    check("par_bad_no_valid", int'(rx_valid), 0);
    send_frame(8'h07, 1'b1, 1'b0);
    check_counts("parity");
`endif

    // Randomized frames with random stalls and random line errors.
    for (int n = 0; n < 40; n++) begin
      rx_ready = ($urandom_range(0, 3) != 0);
      send_frame(DB'($urandom), ($urandom_range(0, 9) != 0), ($urandom_range(0, 9) == 0));
      clks($urandom_range(0, 16));
    end
    rx_ready = 1'b1;
    clks(50);
    check("final_queue_empty", exp_q.size(), 0);
    check("final_busy", int'(busy), 0);
    check_counts("final");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule : tb_uart_rx
